// File: rtl/sha3_msg_packer.sv
// Packs a byte stream MSB-first into 64-bit words for a SHA-3 core.
// A message whose last byte fills a whole word is followed by an all-zero is_last word.
module sha3_msg_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        buffer_full,
    output logic [63:0] out,
    output logic        in_ready,
    output logic        is_last,
    output logic [2:0]  byte_num,
    output logic [15:0] msg_count
);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        EMIT_PAD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic        r_is_last;
    logic        r_pad_pending;
    logic [2:0]  r_byte_num;
    logic [15:0] r_msg_count;

    logic        w_transfer;
    logic        w_word_done;
    logic        w_consume;
    logic        w_emit_consume;
    logic        w_msg_done;
    logic        w_cnt_full;

    assign s_ready        = (r_state == FILL) && !reset;
    assign in_ready       = ((r_state == EMIT) || (r_state == EMIT_PAD)) && !buffer_full && !reset;
    assign w_transfer     = s_valid && s_ready;
    assign w_cnt_full     = (r_cnt == 3'd7);
    assign w_word_done    = w_transfer && (s_last || w_cnt_full);
    assign w_consume      = in_ready;
    assign w_emit_consume = w_consume && (r_state == EMIT);
    assign w_msg_done     = w_consume && (((r_state == EMIT) && r_is_last) || (r_state == EMIT_PAD));

    assign is_last   = ((r_state == EMIT) && r_is_last) || (r_state == EMIT_PAD);
    assign byte_num  = (r_state == EMIT) ? r_byte_num : 3'd0;
    assign msg_count = r_msg_count;

    // One register per byte lane; lanes clear once their word is consumed so
    // the next partial word and the pad word present zeros in unused lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] r_lane;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_lane <= 8'h00;
                end else if (w_emit_consume) begin
                    r_lane <= 8'h00;
                end else if (w_transfer && (r_cnt == 3'(gi))) begin
                    r_lane <= s_data;
                end
            end

            assign out[63 - 8*gi -: 8] = r_lane;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_word_done) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (w_consume) begin
                    w_state_next = r_pad_pending ? EMIT_PAD : FILL;
                end
            end
            EMIT_PAD: begin
                if (w_consume) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // Word attributes are latched with the completing byte and held through EMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= 3'd0;
            r_is_last     <= 1'b0;
            r_pad_pending <= 1'b0;
            r_byte_num    <= 3'd0;
        end else if (w_transfer) begin
            if (w_word_done) begin
                r_cnt         <= 3'd0;
                r_is_last     <= s_last && !w_cnt_full;
                r_pad_pending <= s_last && w_cnt_full;
                r_byte_num    <= (s_last && !w_cnt_full) ? (r_cnt + 3'd1) : 3'd0;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_msg_count <= 16'h0000;
        end else if (w_msg_done) begin
            r_msg_count <= r_msg_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_sha3_msg_packer.sv
// Directed bench for sha3_msg_packer: each scenario task drives bytes and checks words inline.
module tb_sha3_msg_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        buffer_full;
    logic [63:0] out;
    logic        in_ready;
    logic        is_last;
    logic [2:0]  byte_num;
    logic [15:0] msg_count;

    int n_checks = 0;
    int n_pass   = 0;

    sha3_msg_packer dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .buffer_full (buffer_full),
        .out         (out),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .msg_count   (msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [7:0] d, input logic l);
        int c;
        c = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!s_ready && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL push_timeout: s_ready=%0b required 1", s_ready);
        else n_pass++;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic take(output logic [63:0] w, output logic l, output logic [2:0] bn, output int waited);
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL take_timeout: in_ready=%0b required 1", in_ready);
        else n_pass++;
        w  = out;
        l  = is_last;
        bn = byte_num;
        $display("word out=%h is_last=%0b byte_num=%0d waited=%0d", w, l, bn, waited);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %0b want 0", s_ready); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", in_ready); else n_pass++;
        n_checks++; if (out !== 64'h0) $display("FAIL rst_out: got %h want 0", out); else n_pass++;
        n_checks++; if (is_last !== 1'b0) $display("FAIL rst_is_last: got %0b want 0", is_last); else n_pass++;
        n_checks++; if (byte_num !== 3'd0) $display("FAIL rst_byte_num: got %0d want 0", byte_num); else n_pass++;
        n_checks++; if (msg_count !== 16'h0) $display("FAIL rst_msg_count: got %h want 0", msg_count); else n_pass++;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready: got %0b want 1", s_ready); else n_pass++;
        n_checks++; if (out !== 64'h0) $display("FAIL rst_release_out: got %h want 0", out); else n_pass++;
    endtask

    task automatic test_full_pad();
        logic [63:0] w; logic l; logic [2:0] bn; int wt;
        for (int i = 1; i <= 8; i++) push(8'(i), i == 8);
        take(w, l, bn, wt);
        n_checks++; if (wt != 0) $display("FAIL full_latency: waited %0d want 0", wt); else n_pass++;
        n_checks++; if (w !== 64'h0102030405060708) $display("FAIL full_word: got %h want 0102030405060708", w); else n_pass++;
        n_checks++; if (l !== 1'b0 || bn !== 3'd0) $display("FAIL full_flags: is_last=%0b byte_num=%0d want 0/0", l, bn); else n_pass++;
        take(w, l, bn, wt);
        n_checks++; if (wt != 0) $display("FAIL pad_latency: waited %0d want 0", wt); else n_pass++;
        n_checks++; if (w !== 64'h0) $display("FAIL pad_word: got %h want 0", w); else n_pass++;
        n_checks++; if (l !== 1'b1 || bn !== 3'd0) $display("FAIL pad_flags: is_last=%0b byte_num=%0d want 1/0", l, bn); else n_pass++;
        n_checks++; if (msg_count !== 16'd1) $display("FAIL full_msg_count: got %0d want 1", msg_count); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL full_back_to_fill: s_ready=%0b want 1", s_ready); else n_pass++;
    endtask

    task automatic test_partial();
        logic [63:0] w; logic l; logic [2:0] bn; int wt;
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b1);
        take(w, l, bn, wt);
        n_checks++; if (wt != 0) $display("FAIL partial_latency: waited %0d want 0", wt); else n_pass++;
        n_checks++; if (w !== 64'hAABBCC0000000000) $display("FAIL partial_word: got %h want aabbcc0000000000", w); else n_pass++;
        n_checks++; if (l !== 1'b1 || bn !== 3'd3) $display("FAIL partial_flags: is_last=%0b byte_num=%0d want 1/3", l, bn); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL partial_single_word: in_ready=%0b want 0", in_ready); else n_pass++;
        n_checks++; if (msg_count !== 16'd2) $display("FAIL partial_msg_count: got %0d want 2", msg_count); else n_pass++;
    endtask

    task automatic test_multiword();
        logic [63:0] w1, w2; logic l1, l2; logic [2:0] bn1, bn2; int wt;
        w1 = '0; l1 = 1'b1; bn1 = '0;
        for (int i = 0; i < 11; i++) begin
            push(8'(8'h10 + i), i == 10);
            if (i == 7) take(w1, l1, bn1, wt);
        end
        take(w2, l2, bn2, wt);
        n_checks++; if (w1 !== 64'h1011121314151617 || l1 !== 1'b0 || bn1 !== 3'd0)
            $display("FAIL multi_word1: got %h/%0b/%0d want 1011121314151617/0/0", w1, l1, bn1); else n_pass++;
        n_checks++; if (w2 !== 64'h18191A0000000000 || l2 !== 1'b1 || bn2 !== 3'd3)
            $display("FAIL multi_word2: got %h/%0b/%0d want 18191a0000000000/1/3", w2, l2, bn2); else n_pass++;
        n_checks++; if (msg_count !== 16'd3) $display("FAIL multi_msg_count: got %0d want 3", msg_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] w; logic l; logic [2:0] bn; int wt;
        buffer_full = 1'b1;
        push(8'h77, 1'b1);
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %0b want 0", c, in_ready); else n_pass++;
            n_checks++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready: cycle %0d got %0b want 0", c, s_ready); else n_pass++;
            n_checks++; if (out !== 64'h7700000000000000 || is_last !== 1'b1 || byte_num !== 3'd1)
                $display("FAIL bp_hold: cycle %0d got %h/%0b/%0d want 7700000000000000/1/1", c, out, is_last, byte_num); else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++; if (msg_count !== 16'd3) $display("FAIL bp_msg_count_held: got %0d want 3", msg_count); else n_pass++;
        buffer_full = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release: in_ready=%0b want 1", in_ready); else n_pass++;
        take(w, l, bn, wt);
        n_checks++; if (wt != 0 || w !== 64'h7700000000000000) $display("FAIL bp_word: waited %0d got %h want 0/7700000000000000", wt, w); else n_pass++;
        n_checks++; if (msg_count !== 16'd4) $display("FAIL bp_msg_count: got %0d want 4", msg_count); else n_pass++;
    endtask

    task automatic test_invalid_ignored();
        logic [63:0] w; logic l; logic [2:0] bn; int wt;
        s_valid = 1'b0; s_data = 8'hEE; s_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out !== 64'h0 || in_ready !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL invalid_ignored: out=%h in_ready=%0b s_ready=%0b want 0/0/1", out, in_ready, s_ready); else n_pass++;
        push(8'h01, 1'b1);
        take(w, l, bn, wt);
        n_checks++; if (w !== 64'h0100000000000000 || l !== 1'b1 || bn !== 3'd1)
            $display("FAIL first_byte_last: got %h/%0b/%0d want 0100000000000000/1/1", w, l, bn); else n_pass++;
        n_checks++; if (msg_count !== 16'd5) $display("FAIL invalid_msg_count: got %0d want 5", msg_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] w; logic l; logic [2:0] bn; int wt;
        for (int i = 0; i < 5; i++) push(8'(8'h21 + i), 1'b0);
        n_checks++; if (out !== 64'h2122232425000000) $display("FAIL mid_partial: got %h want 2122232425000000", out); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out !== 64'h0 || s_ready !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL mid_reset: out=%h s_ready=%0b in_ready=%0b want 0/0/0", out, s_ready, in_ready); else n_pass++;
        n_checks++; if (msg_count !== 16'd0) $display("FAIL mid_reset_count: got %0d want 0", msg_count); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        push(8'h55, 1'b1);
        take(w, l, bn, wt);
        n_checks++; if (w !== 64'h5500000000000000 || l !== 1'b1 || bn !== 3'd1)
            $display("FAIL mid_next_msg: got %h/%0b/%0d want 5500000000000000/1/1", w, l, bn); else n_pass++;
        n_checks++; if (msg_count !== 16'd1) $display("FAIL mid_msg_count: got %0d want 1", msg_count); else n_pass++;
        // Reset while a full word waits in EMIT behind back-pressure.
        buffer_full = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h31 + i), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        buffer_full = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b0 || out !== 64'h0 || s_ready !== 1'b1 || msg_count !== 16'd0)
            $display("FAIL emit_reset: in_ready=%0b out=%h s_ready=%0b msg_count=%0d want 0/0/1/0", in_ready, out, s_ready, msg_count); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [63:0] w; logic l; logic [2:0] bn; int wt;
        // Jump the counter just short of its wrap point instead of streaming 65534 messages.
        force dut.r_msg_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_msg_count;
        push(8'h42, 1'b1);
        take(w, l, bn, wt);
        n_checks++; if (msg_count !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want ffff", msg_count); else n_pass++;
        push(8'h43, 1'b1);
        take(w, l, bn, wt);
        n_checks++; if (msg_count !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", msg_count); else n_pass++;
        n_checks++; if (w !== 64'h4300000000000000 || l !== 1'b1 || bn !== 3'd1)
            $display("FAIL wrap_word: got %h/%0b/%0d want 4300000000000000/1/1", w, l, bn); else n_pass++;
        push(8'h44, 1'b1);
        take(w, l, bn, wt);
        n_checks++; if (msg_count !== 16'h0001) $display("FAIL wrap_after: got %h want 0001", msg_count); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        s_data = 8'h00;
        s_valid = 1'b0;
        s_last = 1'b0;
        buffer_full = 1'b0;
        test_reset();
        test_full_pad();
        test_partial();
        test_multiword();
        test_backpressure();
        test_invalid_ignored();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha3_msg_packer.md
SHA3_MSG_PACKER -- requirements
Module: sha3_msg_packer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s_data  input  8  message byte from the upstream source.
REQ-005 s_valid  input  1  s_data is valid this cycle.
REQ-006 s_last  input  1  the current byte is the final byte of the message; qualified by s_valid.
REQ-007 s_ready  output  1  the packer accepts a byte this cycle.
REQ-008 buffer_full  input  1  the downstream sha3 core cannot take a word this cycle.
REQ-009 out  output  64  packed word for the sha3 core.
REQ-010 in_ready  output  1  strobe: out, is_last and byte_num are presented and consumed this cycle.
REQ-011 is_last  output  1  the word is the final word of the message.
REQ-012 byte_num  output  3  valid byte count of the final word (0-7); 0 when is_last=0.
REQ-013 msg_count  output  16  number of messages fully delivered, wrapping.

Function
REQ-014 A byte transfer SHALL occur only on a cycle with s_valid=1 and s_ready=1.
REQ-015 The packer SHALL pack bytes MSB-first: byte k of a word (k=0..7) occupies out[63-8k -: 8].
REQ-016 Unfilled byte lanes of a partial word SHALL be driven to zero.
REQ-017 States SHALL be FILL, EMIT, EMIT_PAD; reset state is FILL with byte count 0.
REQ-018 s_ready SHALL be 1 only in FILL; it SHALL be 0 in EMIT and EMIT_PAD regardless of buffer_full.
REQ-019 FILL -> EMIT SHALL occur on the transfer of the 8th byte of a word or of any byte with s_last=1.
REQ-020 in_ready SHALL equal (state is EMIT or EMIT_PAD) AND NOT buffer_full, combinationally; a word is consumed on every cycle in_ready=1.
REQ-021 While buffer_full=1 in EMIT/EMIT_PAD, out, is_last and byte_num SHALL hold stable and the state SHALL not change.
REQ-022 Full word, not last: EMIT presents is_last=0, byte_num=0; on consumption -> FILL, byte count 0.
REQ-023 Last byte at count n=1..7: EMIT presents is_last=1, byte_num=n; on consumption -> FILL and msg_count increments.
REQ-024 Last byte completing 8 bytes: EMIT presents is_last=0, byte_num=0; on consumption -> EMIT_PAD.
REQ-025 EMIT_PAD SHALL present out=0, is_last=1, byte_num=0; on consumption -> FILL and msg_count increments.
REQ-026 Latency from the accepting edge of the completing byte to in_ready SHALL be exactly 1 cycle when buffer_full=0.
REQ-027 msg_count SHALL wrap from 0xFFFF to 0x0000 without any other effect.
REQ-028 s_last on a byte SHALL be honoured even if it is the first byte of a message (n=1).
REQ-029 s_data/s_last presented with s_valid=0 SHALL have no effect.

Reset
REQ-030 Reset SHALL return the state to FILL, clear the byte count, the packing register (out=0) and msg_count, and drive in_ready=0, is_last=0, byte_num=0.
REQ-031 While reset=1, s_ready SHALL be 0 and no byte or word transfer SHALL occur.
REQ-032 Reset asserted mid-word or in EMIT/EMIT_PAD SHALL discard the partial message; msg_count SHALL not increment for it.

Verification
REQ-033 Bytes 0x01..0x08, s_last on 0x08, buffer_full=0 -> in_ready with out=0x0102030405060708, is_last=0; next in_ready with out=0, is_last=1, byte_num=0; msg_count=1.
REQ-034 Bytes 0xAA,0xBB,0xCC, s_last on 0xCC -> one in_ready, out=0xAABBCC0000000000, is_last=1, byte_num=3, exactly 1 cycle after the 0xCC accept.
REQ-035 11 bytes 0x10..0x1A, s_last on 0x1A -> word 0x1011121314151617 with is_last=0, then 0x18191A0000000000 with is_last=1, byte_num=3.
REQ-036 Hold buffer_full=1 for 5 cycles while in EMIT -> in_ready=0, s_ready=0, out stable; word consumed on first cycle buffer_full=0.
REQ-037 Assert reset after 5 of 8 bytes -> out=0, s_ready=0 during reset; next message 0x55 (last) yields out=0x5500000000000000, byte_num=1, msg_count=1.
REQ-038 Preload 65535 single-byte messages -> next completed message sets msg_count=0x0000.
